rv32_lsu: RTL and testbench

Multi-cycle load/store unit for the rv32 core. Sits downstream of instruction decode, consuming its memory control signals (enable, function, type), and upstream of a data memory with a valid/ready request channel and a response-valid return channel. Handles byte-lane alignment, write byte enables, and load sign/zero extension. Stalls the core while an access is outstanding.

---
 rtl/rv32_lsu_pkg.sv | 48 ++++
 rtl/rv32_lsu_align.sv | 52 +++++
 rtl/rv32_lsu.sv | 109 ++++++++++
 tb/tb_rv32_lsu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_lsu_pkg.sv
// Shared rv32 core constants: memory access type (t_mt), memory function (t_m),
// and the load/store unit FSM state (t_lsu_state). Also provides the access
// legality helper used by the LSU alignment logic.
package rv32_lsu_pkg;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_D  = 3'd4,
        MT_BU = 3'd5,
        MT_HU = 3'd6,
        MT_WU = 3'd7
    } t_mt;

    typedef enum logic {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } t_m;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } t_lsu_state;

    // Formatted store side of an access: legality, lane enables, lane data.
    typedef struct packed {
        logic        legal;
        logic [3:0]  be;
        logic [31:0] wdata;
    } t_lsu_fmt;

    // Only naturally aligned B/H/W accesses are supported on rv32.
    function automatic logic lsu_legal(input t_mt typ, input logic [1:0] off);
        logic ok;
        case (typ)
            MT_B, MT_BU: ok = 1'b1;
            MT_H, MT_HU: ok = ~off[0];
            MT_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational byte-lane alignment for the LSU.
//   i_st_typ/i_st_off/i_st_wdata : incoming request type, addr[1:0], rs2 data
//   o_fmt                        : legality, byte enables, lane-replicated data
//   i_ld_typ/i_ld_off/i_rdata    : latched load type, addr[1:0], memory word
//   o_ld_data                    : extracted and sign/zero-extended load data
module rv32_lsu_align
    import rv32_lsu_pkg::*;
(
    input  t_mt         i_st_typ,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    input  t_mt         i_ld_typ,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output t_lsu_fmt    o_fmt,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        o_fmt.legal = lsu_legal(i_st_typ, i_st_off);
        o_fmt.be    = 4'b0000;
        o_fmt.wdata = i_st_wdata;
        case (i_st_typ)
            MT_B, MT_BU: begin
                o_fmt.be    = 4'b0001 << i_st_off;
                o_fmt.wdata = {4{i_st_wdata[7:0]}};
            end
            MT_H, MT_HU: begin
                o_fmt.be    = 4'b0011 << i_st_off;
                o_fmt.wdata = {2{i_st_wdata[15:0]}};
            end
            MT_W:    o_fmt.be = 4'b1111;
            default: o_fmt.be = 4'b0000;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend.
    always_comb begin
        w_shifted = i_rdata >> {i_ld_off, 3'b000};
        case (i_ld_typ)
            MT_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MT_BU:   o_ld_data = {24'd0, w_shifted[7:0]};
            MT_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MT_HU:   o_ld_data = {16'd0, w_shifted[15:0]};
            MT_W:    o_ld_data = i_rdata;
            default: o_ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_lsu.sv
// Multi-cycle rv32 load/store unit.
//   i_req_*   : decoded memory op (valid/fcn/typ/addr/wdata), held while o_stall
//   o_stall   : core holds PC/instruction while an access is outstanding
//   o_resp_*  : one-cycle completion pulse with extended load data
//   o_misalign: one-cycle pulse on an illegal access (no memory traffic)
//   o_mem_*/i_mem_* : valid/ready request channel and response-valid return
module rv32_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  t_m                i_req_fcn,
    input  t_mt               i_req_typ,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_stall,
    output logic              o_resp_valid,
    output logic [XLEN-1:0]   o_resp_rdata,
    output logic              o_misalign,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_resp_valid,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    t_lsu_state        r_state;
    logic              r_we;
    t_mt               r_typ;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_resp_rdata;

    t_lsu_fmt          w_fmt;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_idle;

    // Store formatting uses the live request; load extraction uses the
    // latched type/offset since the response arrives cycles later.
    rv32_lsu_align u_align (
        .i_st_typ   (i_req_typ),
        .i_st_off   (i_req_addr[1:0]),
        .i_st_wdata (i_req_wdata),
        .i_ld_typ   (r_typ),
        .i_ld_off   (r_addr[1:0]),
        .i_rdata    (i_mem_rdata),
        .o_fmt      (w_fmt),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= LSU_IDLE;
            r_we         <= 1'b0;
            r_typ        <= MT_X;
            r_addr       <= '0;
            r_be         <= 4'b0000;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (i_req_valid && w_fmt.legal) begin
                        r_we    <= (i_req_fcn == M_XWR);
                        r_typ   <= i_req_typ;
                        r_addr  <= i_req_addr;
                        r_be    <= w_fmt.be;
                        r_wdata <= w_fmt.wdata;
                        r_state <= LSU_REQ;
                    end
                end
                // A response seen here (even alongside ready) is stale.
                LSU_REQ: begin
                    if (i_mem_req_ready)
                        r_state <= LSU_WAIT;
                end
                LSU_WAIT: begin
                    if (i_mem_resp_valid) begin
                        r_resp_rdata <= r_we ? '0 : w_ld_data;
                        r_state      <= LSU_DONE;
                    end
                end
                LSU_DONE: r_state <= LSU_IDLE;
                default:  r_state <= LSU_IDLE;
            endcase
        end
    end

    assign w_idle          = (r_state == LSU_IDLE);
    assign o_stall         = (w_idle && i_req_valid && w_fmt.legal) ||
                             (r_state == LSU_REQ) || (r_state == LSU_WAIT);
    assign o_misalign      = w_idle && i_req_valid && !w_fmt.legal;
    assign o_resp_valid    = (r_state == LSU_DONE);
    assign o_resp_rdata    = r_resp_rdata;
    assign o_mem_req_valid = (r_state == LSU_REQ);
    assign o_mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_mem_we        = r_we;
    assign o_mem_be        = r_be;
    assign o_mem_wdata     = r_wdata;

endmodule

// File: tb/tb_rv32_lsu.sv
module tb_rv32_lsu;
    import rv32_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    t_m          req_fcn = M_XRD;
    t_mt         req_typ = MT_X;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, resp_valid, misalign, mem_req_valid, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errs = 0;
    int checks = 0;
    int resp_cnt = 0;
    int exp_resp = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    rv32_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .i_req_fcn        (req_fcn),
        .i_req_typ        (req_typ),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_stall          (stall),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_misalign       (misalign),
        .o_mem_req_valid  (mem_req_valid),
        .i_mem_req_ready  (mem_req_ready),
        .o_mem_addr       (mem_addr),
        .o_mem_we         (mem_we),
        .o_mem_be         (mem_be),
        .o_mem_wdata      (mem_wdata),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every completion pops the oldest expected load data.
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else                  chk("resp_rdata", resp_rdata, sb_q.pop_front());
        end
    end

    // Drives one legal access and plays the memory. rdly = cycles of
    // ready low in REQ, wdly = response delay cycles in WAIT, same_cyc =
    // also raise a (stale) response alongside ready.
    task automatic run_op(input string tag, input t_m fcn, input t_mt typ,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rdly, input int wdly,
                          input bit same_cyc, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata, input int e_stall);
        int nreq, nwait, nstall;
        bit done;
        nreq = 0; nwait = 0; nstall = 0; done = 0;
        sb_q.push_back(e_rdata);
        exp_resp++;
        @(negedge clk);
        req_valid = 1'b1; req_fcn = fcn; req_typ = typ;
        req_addr = addr; req_wdata = wdata;
        #1;
        chk({tag, "_acc_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_acc_misalign"}, {31'd0, misalign}, 32'd0);
        nstall = 1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
                req_valid = 1'b0;
                mem_resp_valid = 1'b0;
                done = 1;
            end else if (mem_req_valid) begin
                nstall++;
                chk({tag, "_addr"}, mem_addr, e_addr);
                chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, e_be});
                chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, fcn == M_XWR});
                chk({tag, "_wdata"}, mem_wdata, e_wdata);
                mem_resp_valid = 1'b0;
                if (nreq < rdly) mem_req_ready = 1'b0;
                else begin
                    mem_req_ready  = 1'b1;
                    mem_resp_valid = same_cyc;
                    mem_rdata      = ~rdata;
                end
                nreq++;
            end else if (stall) begin
                nstall++;
                mem_req_ready = 1'b0;
                if (nwait < wdly) mem_resp_valid = 1'b0;
                else begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = rdata;
                end
                nwait++;
            end else begin
                chk({tag, "_dropped"}, 32'd1, 32'd0);
                req_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'd1, 32'd0);
            req_valid = 1'b0;
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        chk({tag, "_stall_cycles"}, nstall, e_stall);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("lw", M_XRD, MT_W, 32'h2004, 32'h0, 32'hDEADBEEF, 0, 0, 0,
               32'h2004, 4'b1111, 32'h0, 32'hDEADBEEF, 3);
        run_op("lb", M_XRD, MT_B, 32'h2003, 32'h0, 32'h80123456, 0, 0, 0,
               32'h2000, 4'b1000, 32'h0, 32'hFFFFFF80, 3);
        run_op("lbu", M_XRD, MT_BU, 32'h2003, 32'h0, 32'h80123456, 0, 0, 0,
               32'h2000, 4'b1000, 32'h0, 32'h00000080, 3);
        run_op("sh", M_XWR, MT_H, 32'h2002, 32'h1234ABCD, 32'h55555555, 0, 0, 0,
               32'h2000, 4'b1100, 32'hABCDABCD, 32'h0, 3);
        run_op("lh", M_XRD, MT_H, 32'h2002, 32'h0, 32'h80015678, 0, 1, 0,
               32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 4);
        run_op("lhu", M_XRD, MT_HU, 32'h2000, 32'h0, 32'h1234F00D, 1, 0, 0,
               32'h2000, 4'b0011, 32'h0, 32'h0000F00D, 4);
        run_op("sb", M_XWR, MT_B, 32'h2001, 32'h000000AB, 32'h0, 0, 0, 0,
               32'h2000, 4'b0010, 32'hABABABAB, 32'h0, 3);
        run_op("sw_bp", M_XWR, MT_W, 32'h2008, 32'hCAFEF00D, 32'h0, 3, 2, 0,
               32'h2008, 4'b1111, 32'hCAFEF00D, 32'h0, 8);
        run_op("lw_same", M_XRD, MT_W, 32'h3000, 32'h0, 32'h0BADC0DE, 0, 0, 1,
               32'h3000, 4'b1111, 32'h0, 32'h0BADC0DE, 3);

        // Misaligned word and an unsupported type: pulse only, no traffic.
        @(negedge clk);
        req_valid = 1'b1; req_fcn = M_XRD; req_typ = MT_W; req_addr = 32'h2001;
        #1;
        chk("mis_lw_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_lw_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("mis_lw_noreq", {31'd0, mem_req_valid}, 32'd0);
        req_typ = MT_D; req_addr = 32'h2000;
        #1;
        chk("mis_d_pulse", {31'd0, misalign}, 32'd1);
        req_valid = 1'b0;
        #1;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        chk("mis_d_noreq", {31'd0, mem_req_valid}, 32'd0);

        // Reset while in WAIT, then a late response that must be ignored.
        req_valid = 1'b1; req_fcn = M_XWR; req_typ = MT_W;
        req_addr = 32'h200C; req_wdata = 32'h11112222;
        @(negedge clk);
        chk("rmid_in_req", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rmid_in_wait", {31'd0, stall & ~mem_req_valid}, 32'd1);
        rst_n = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rmid_stall", {31'd0, stall}, 32'd0);
        chk("rmid_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rmid_we", {31'd0, mem_we}, 32'd0);
        chk("rmid_be", {28'd0, mem_be}, 32'd0);
        chk("rmid_addr", mem_addr, 32'd0);
        chk("rmid_wdata", mem_wdata, 32'd0);
        chk("rmid_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_rdata = 32'h99999999;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("late_stall", {31'd0, stall}, 32'd0);
        end

        chk("resp_count", resp_cnt, exp_resp);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
